// File: rtl/bsg_mux_rr_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : bsg_mux_rr_pipe_if
// Brief    : N-channel producer side plus single consumer side of the rr mux.
// Revision : 1.0
// ============================================================================
interface bsg_mux_rr_pipe_if #(
  parameter int width_p   = 8,
  parameter int els_p     = 4,
  parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
);
  logic [els_p-1:0]              v_i;
  logic [els_p-1:0][width_p-1:0] data_i;
  logic [els_p-1:0]              last_i;
  logic [els_p-1:0]              ready_o;
  logic                          v_o;
  logic [width_p-1:0]            data_o;
  logic [lg_els_lp-1:0]          sel_o;
  logic                          last_o;
  logic                          ready_i;

  modport slave (
    input  v_i, data_i, last_i, ready_i,
    output ready_o, v_o, data_o, sel_o, last_o
  );

  modport master (
    output v_i, data_i, last_i, ready_i,
    input  ready_o, v_o, data_o, sel_o, last_o
  );
endinterface
`default_nettype wire

// File: rtl/bsg_mux_rr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bsg_mux_rr_pipe
// Brief    : Registered round-robin N:1 valid/ready mux with optional packet lock.
// Revision : 1.0
// ============================================================================
module bsg_mux_rr_pipe #(
  parameter int width_p   = 8,
  parameter int els_p     = 4,
  parameter int locking_p = 0,
  parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  bsg_mux_rr_pipe_if.slave ch
);

  typedef enum logic [0:0] {
    LK_IDLE = 1'b0,
    LK_HOLD = 1'b1
  } lock_state_e;

  localparam logic [lg_els_lp:0] els_lp = (lg_els_lp+1)'(els_p);
  localparam logic [lg_els_lp:0] one_lp = (lg_els_lp+1)'(1);

  lock_state_e            lock_r, lock_n;
  logic [lg_els_lp-1:0]   lock_ch_r, lock_ch_n;
  logic [lg_els_lp-1:0]   ptr_r, ptr_n;
  logic [lg_els_lp-1:0]   grant;
  logic [lg_els_lp:0]     off, g_inc;
  logic [2*els_p-1:0]     v_rot;
  logic [els_p-1:0]       ready;
  logic                   can_accept, any_v, accept, grant_last;

  logic                   v_r, last_r;
  logic [width_p-1:0]     data_r;
  logic [lg_els_lp-1:0]   sel_r;

  assign can_accept = ~v_r | ch.ready_i;

  // Rotate valids so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    v_rot = {ch.v_i, ch.v_i} >> ptr_r;
    off   = '0;
    any_v = 1'b0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (v_rot[i]) begin
        off   = (lg_els_lp+1)'(i);
        any_v = 1'b1;
      end
    end
    off = off + {1'b0, ptr_r};
    if (off >= els_lp) off = off - els_lp;
    grant = off[lg_els_lp-1:0];
    if (lock_r == LK_HOLD) begin
      grant = lock_ch_r;
      any_v = 1'b1;
    end
  end

  always_comb begin
    ready = '0;
    if (!reset_i && can_accept && any_v) ready[grant] = 1'b1;
  end

  assign accept     = |(ch.v_i & ready);
  assign grant_last = ch.last_i[grant];

  always_comb begin
    g_inc = {1'b0, grant} + one_lp;
    if (g_inc >= els_lp) g_inc = '0;
  end

  // Pointer advances past a packet only once its final beat is taken.
  always_comb begin
    lock_n    = lock_r;
    lock_ch_n = lock_ch_r;
    ptr_n     = ptr_r;
    if (accept) begin
      if (locking_p == 0 || grant_last) ptr_n = g_inc[lg_els_lp-1:0];
      if (locking_p != 0) begin
        if (grant_last) begin
          lock_n = LK_IDLE;
        end else begin
          lock_n    = LK_HOLD;
          lock_ch_n = grant;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_r    <= LK_IDLE;
      lock_ch_r <= '0;
      ptr_r     <= '0;
    end else begin
      lock_r    <= lock_n;
      lock_ch_r <= lock_ch_n;
      ptr_r     <= ptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r    <= 1'b0;
      data_r <= '0;
      sel_r  <= '0;
      last_r <= 1'b0;
    end else if (accept) begin
      v_r    <= 1'b1;
      data_r <= ch.data_i[grant];
      sel_r  <= grant;
      last_r <= grant_last;
    end else if (ch.ready_i) begin
      v_r    <= 1'b0;
    end
  end

  assign ch.ready_o = ready;
  assign ch.v_o     = v_r;
  assign ch.data_o  = data_r;
  assign ch.sel_o   = sel_r;
  assign ch.last_o  = last_r;

endmodule
`default_nettype wire

// File: tb/tb_bsg_mux_rr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_mux_rr_pipe
// Brief    : Directed vector bench: 4-ch unlocked, 4-ch locking, 1-ch instances.
// Revision : 1.0
// ============================================================================
module tb_bsg_mux_rr_pipe;

  typedef struct {
    bit [1:0] dut;
    bit       rst;
    bit [3:0] v;
    bit [3:0] last;
    bit       rdy;
    bit [3:0] e_ready;
    bit       e_vo;
    bit [1:0] e_sel;
    bit       e_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bsg_mux_rr_pipe_if #(.width_p(8), .els_p(4)) ifa ();
  bsg_mux_rr_pipe_if #(.width_p(8), .els_p(4)) ifb ();
  bsg_mux_rr_pipe_if #(.width_p(8), .els_p(1)) ifc ();

  bsg_mux_rr_pipe #(.width_p(8), .els_p(4), .locking_p(0)) u_a (
    .clk_i(clk), .reset_i(rst_a), .ch(ifa.slave));
  bsg_mux_rr_pipe #(.width_p(8), .els_p(4), .locking_p(1)) u_b (
    .clk_i(clk), .reset_i(rst_b), .ch(ifb.slave));
  bsg_mux_rr_pipe #(.width_p(8), .els_p(1), .locking_p(0)) u_c (
    .clk_i(clk), .reset_i(rst_c), .ch(ifc.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit [1:0] dut, bit rst, bit [3:0] v, bit [3:0] last, bit rdy,
                              bit [3:0] er, bit evo, bit [1:0] es, bit el);
    vec_t t;
    t.dut = dut; t.rst = rst; t.v = v; t.last = last; t.rdy = rdy;
    t.e_ready = er; t.e_vo = evo; t.e_sel = es; t.e_last = el;
    return t;
  endfunction

  task automatic apply(input vec_t t, input int n);
    logic [3:0] r;
    logic       vo, l;
    logic [1:0] s;
    logic [7:0] d;
    @(negedge clk);
    if (t.dut == 0) begin
      rst_a = t.rst; ifa.v_i = t.v; ifa.last_i = t.last; ifa.ready_i = t.rdy;
    end else begin
      rst_b = t.rst; ifb.v_i = t.v; ifb.last_i = t.last; ifb.ready_i = t.rdy;
    end
    #2;
    if (t.dut == 0) begin
      r = ifa.ready_o; vo = ifa.v_o; s = ifa.sel_o; d = ifa.data_o; l = ifa.last_o;
    end else begin
      r = ifb.ready_o; vo = ifb.v_o; s = ifb.sel_o; d = ifb.data_o; l = ifb.last_o;
    end
    chk($sformatf("vec%0d.ready_o", n), 32'(r), 32'(t.e_ready));
    chk($sformatf("vec%0d.v_o", n), 32'(vo), 32'(t.e_vo));
    if (t.e_vo) begin
      chk($sformatf("vec%0d.sel_o", n), 32'(s), 32'(t.e_sel));
      chk($sformatf("vec%0d.data_o", n), 32'(d), 32'(8'h10 + 8'(t.e_sel)));
      chk($sformatf("vec%0d.last_o", n), 32'(l), 32'(t.e_last));
    end
  endtask

  task automatic step_c(input string name, input bit v, input logic [7:0] din, input bit rdy,
                        input bit e_ready, input bit e_vo, input logic [7:0] e_data);
    @(negedge clk);
    ifc.v_i = v; ifc.data_i[0] = din; ifc.ready_i = rdy;
    #2;
    chk({name, ".ready_o"}, 32'(ifc.ready_o), 32'(e_ready));
    chk({name, ".v_o"}, 32'(ifc.v_o), 32'(e_vo));
    if (e_vo) begin
      chk({name, ".data_o"}, 32'(ifc.data_o), 32'(e_data));
      chk({name, ".sel_o"}, 32'(ifc.sel_o), 32'(0));
    end
  endtask

  vec_t vecs[$];

  initial begin
    // Unlocked 4-channel: streaming, backpressure, sparse and wrapping grants.
    vecs.push_back(mk(0,0,4'b1111,4'b0101,1, 4'b0001,0,0,0));
    vecs.push_back(mk(0,0,4'b1111,4'b0101,1, 4'b0010,1,0,1));
    vecs.push_back(mk(0,0,4'b1111,4'b0101,1, 4'b0100,1,1,0));
    vecs.push_back(mk(0,0,4'b1111,4'b0101,1, 4'b1000,1,2,1));
    vecs.push_back(mk(0,0,4'b1111,4'b0101,1, 4'b0001,1,3,0));
    vecs.push_back(mk(0,0,4'b0000,4'b0101,1, 4'b0000,1,0,1));
    vecs.push_back(mk(0,0,4'b0100,4'b0101,0, 4'b0100,0,0,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,4'b0100,4'b0101,0, 4'b0000,1,2,1));
    vecs.push_back(mk(0,0,4'b0100,4'b0101,1, 4'b0100,1,2,1));
    vecs.push_back(mk(0,0,4'b0011,4'b0101,1, 4'b0001,1,2,1));
    vecs.push_back(mk(0,0,4'b0011,4'b0101,1, 4'b0010,1,0,1));
    vecs.push_back(mk(0,0,4'b1000,4'b0101,1, 4'b1000,1,1,0));
    vecs.push_back(mk(0,0,4'b0011,4'b0101,1, 4'b0001,1,3,0));
    vecs.push_back(mk(0,0,4'b1010,4'b0101,1, 4'b0010,1,0,1));
    vecs.push_back(mk(0,0,4'b0000,4'b0101,0, 4'b0000,1,1,0));
    vecs.push_back(mk(0,0,4'b0000,4'b0101,1, 4'b0000,1,1,0));
    vecs.push_back(mk(0,0,4'b0000,4'b0101,1, 4'b0000,0,0,0));
    // Locking 4-channel: 3-beat packet on ch1, starvation, then reset mid-packet.
    vecs.push_back(mk(1,0,4'b0001,4'b0001,1, 4'b0001,0,0,0));
    vecs.push_back(mk(1,0,4'b0111,4'b0000,1, 4'b0010,1,0,1));
    vecs.push_back(mk(1,0,4'b0111,4'b0000,1, 4'b0010,1,1,0));
    vecs.push_back(mk(1,0,4'b0101,4'b0000,1, 4'b0010,1,1,0));
    vecs.push_back(mk(1,0,4'b0111,4'b0010,1, 4'b0010,0,0,0));
    vecs.push_back(mk(1,0,4'b0101,4'b0101,1, 4'b0100,1,1,1));
    vecs.push_back(mk(1,0,4'b0001,4'b0001,1, 4'b0001,1,2,1));
    vecs.push_back(mk(1,0,4'b0000,4'b0000,1, 4'b0000,1,0,1));
    vecs.push_back(mk(1,0,4'b0010,4'b0000,1, 4'b0010,0,0,0));
    vecs.push_back(mk(1,1,4'b0011,4'b0000,1, 4'b0000,1,1,0));
    vecs.push_back(mk(1,0,4'b0011,4'b0011,1, 4'b0001,0,0,0));
    vecs.push_back(mk(1,0,4'b0000,4'b0000,1, 4'b0000,1,0,1));
    vecs.push_back(mk(1,0,4'b0000,4'b0000,1, 4'b0000,0,0,0));

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.v_i = 4'b1111; ifa.last_i = '0; ifa.ready_i = 1'b1;
    ifb.v_i = 4'b0000; ifb.last_i = '0; ifb.ready_i = 1'b1;
    ifc.v_i = 1'b1; ifc.last_i = 1'b1; ifc.ready_i = 1'b1; ifc.data_i[0] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      ifa.data_i[k] = 8'h10 + 8'(k);
      ifb.data_i[k] = 8'h10 + 8'(k);
    end

    @(negedge clk);
    #2;
    chk("rst.ready_o_a", 32'(ifa.ready_o), 32'(0));
    chk("rst.ready_o_c", 32'(ifc.ready_o), 32'(0));
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ifa.v_i = 4'b0000; ifc.v_i = 1'b0;
    #2;
    chk("rst.v_o_a", 32'(ifa.v_o), 32'(0));
    chk("rst.data_o_a", 32'(ifa.data_o), 32'(0));
    chk("rst.sel_o_a", 32'(ifa.sel_o), 32'(0));
    chk("rst.last_o_a", 32'(ifa.last_o), 32'(0));
    chk("rst.v_o_b", 32'(ifb.v_o), 32'(0));
    chk("rst.v_o_c", 32'(ifc.v_o), 32'(0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Single channel: two beats with the consumer stalling between them.
    step_c("c1", 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);
    step_c("c2", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'hA5);
    step_c("c3", 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'hA5);
    step_c("c4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A);
    step_c("c5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
